// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared widths, reset PC and fetch entry type for the fetch stage
package fetch_stage_pkg;

    localparam int PC_W   = 16;
    localparam int INST_W = 32;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pred_npc;
    } fetch_entry_t;

    // Instructions are word aligned, so a predicted target never carries low bits.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
        return a & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - imem, btb, redirect and decode-side signals of the fetch stage
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic              imem_en;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic [PC_W-1:0]   btb_pc;
    logic [PC_W-1:0]   btb_npc;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pred_npc;

    modport master (
        output imem_en, imem_addr, btb_pc, out_valid, out_pc, out_inst, out_pred_npc,
        input  imem_rdata, btb_npc, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_en, imem_addr, btb_pc, out_valid, out_pc, out_inst, out_pred_npc,
        output imem_rdata, btb_npc, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order fetch entry FIFO with flush, concurrent push/pop at any occupancy
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic                   not_empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_pop    = pop && (count != '0);
    assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign not_empty = (count != '0);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !(rst || flush)) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC sequencing, one-deep imem fetch slot and fetch queue; FETCH_BTB_PRED_EN selects BTB prediction
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              FQ_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pred_npc;
    logic             inflight_valid;
    logic [PC_W-1:0]  inflight_pc;
    logic [PC_W-1:0]  inflight_npc;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] occupancy;
    logic             q_not_empty;
    logic             issue_ok;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     q_head;

    always_comb begin
        pred_npc = '0;
`ifdef FETCH_BTB_PRED_EN
        pred_npc = align_pc(bus.btb_npc);
`else
        pred_npc = align_pc(pc + PC_W'(4));
`endif
    end

    // The in-flight fetch already owns a queue slot; occupancy is taken before any pop.
    assign occupancy = q_count + CNT_W'(inflight_valid);
    assign issue_ok  = !rst && !bus.redirect_valid && (occupancy < CNT_W'(FQ_DEPTH));

    assign bus.imem_en   = issue_ok;
    assign bus.imem_addr = pc;
    assign bus.btb_pc    = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            inflight_valid <= 1'b0;
            inflight_pc    <= '0;
            inflight_npc   <= '0;
        end else if (bus.redirect_valid) begin
            pc             <= bus.redirect_pc;
            inflight_valid <= 1'b0;
        end else begin
            inflight_valid <= issue_ok;
            if (issue_ok) begin
                pc           <= pred_npc;
                inflight_pc  <= pc;
                inflight_npc <= pred_npc;
            end
        end
    end

    assign push_entry = '{pc: inflight_pc, inst: bus.imem_rdata, pred_npc: inflight_npc};
    assign push       = inflight_valid && !bus.redirect_valid;
    assign pop        = bus.out_valid && bus.out_ready && !bus.redirect_valid;

    fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (q_head),
        .not_empty (q_not_empty),
        .count     (q_count)
    );

    assign bus.out_valid    = q_not_empty && !rst;
    assign bus.out_pc       = q_head.pc;
    assign bus.out_inst     = q_head.inst;
    assign bus.out_pred_npc = q_head.pred_npc;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   btb_mode = 0;

    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(16'h0000), .FQ_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always_comb begin
        case (btb_mode)
            1:       bus.btb_npc = 16'h0100;
            2:       bus.btb_npc = (bus.btb_pc == 16'h0008) ? 16'h0100 : bus.btb_pc + 16'd4;
            default: bus.btb_npc = bus.btb_pc + 16'd4;
        endcase
    end

    always @(posedge clk) bus.imem_rdata <= {16'hA5A5, bus.imem_addr};

    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.out_ready = ready;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0040;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL rst_imem_en: got %b expected 0", bus.imem_en); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL rst2_imem_en: got %b expected 0", bus.imem_en); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_first_fetch: got en=%b addr=%h expected en=1 addr=0000", bus.imem_en, bus.imem_addr); end
        checks++; if (bus.btb_pc !== 16'h0000) begin errors++; $display("FAIL rst_btb_pc: got %h expected 0000", bus.btb_pc); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_cycle0_out_valid: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_sequential(input int mode);
        logic [15:0] exp_pc;
        btb_mode = mode;
        do_reset(1'b1);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 16'(4 * k)) begin errors++; $display("FAIL seq%0d_fetch c%0d: got en=%b addr=%h expected en=1 addr=%h", mode, k, bus.imem_en, bus.imem_addr, 16'(4 * k)); end
            if (k >= 2) begin
                exp_pc = 16'(4 * (k - 2));
                checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_inst !== {16'hA5A5, exp_pc} || bus.out_pred_npc !== exp_pc + 16'd4) begin errors++; $display("FAIL seq%0d_out c%0d: got v=%b pc=%h inst=%h npc=%h expected pc=%h", mode, k, bus.out_valid, bus.out_pc, bus.out_inst, bus.out_pred_npc, exp_pc); end
            end else begin
                checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL seq%0d_early c%0d: got out_valid=%b expected 0", mode, k, bus.out_valid); end
            end
        end
        btb_mode = 0;
    endtask

    task automatic test_btb_taken();
        logic [15:0] exp_fetch [5];
        logic [15:0] exp_npc [4];
        exp_fetch = '{16'h0000, 16'h0004, 16'h0008, 16'h0100, 16'h0104};
        exp_npc   = '{16'h0004, 16'h0008, 16'h0100, 16'h0104};
        btb_mode = 2;
        do_reset(1'b1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            if (k < 5) begin
                checks++; if (bus.imem_addr !== exp_fetch[k]) begin errors++; $display("FAIL btb_fetch c%0d: got %h expected %h", k, bus.imem_addr, exp_fetch[k]); end
            end
            if (k >= 2) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_fetch[k-2] || bus.out_pred_npc !== exp_npc[k-2]) begin errors++; $display("FAIL btb_out c%0d: got v=%b pc=%h npc=%h expected pc=%h npc=%h", k, bus.out_valid, bus.out_pc, bus.out_pred_npc, exp_fetch[k-2], exp_npc[k-2]); end
            end
        end
        btb_mode = 0;
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            checks++; if (bus.imem_en !== (k < 4)) begin errors++; $display("FAIL bp_imem_en c%0d: got %b expected %b", k, bus.imem_en, (k < 4)); end
        end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0000) begin errors++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=0000", bus.out_valid, bus.out_pc); end
        for (int k = 10; k < 17; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'(4 * (k - 10))) begin errors++; $display("FAIL bp_drain c%0d: got v=%b pc=%h expected v=1 pc=%h", k, bus.out_valid, bus.out_pc, 16'(4 * (k - 10))); end
            if (k == 10) begin
                checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL bp_full_pop: got imem_en=%b expected 0", bus.imem_en); end
            end
            if (k == 11) begin
                checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 16'h0010) begin errors++; $display("FAIL bp_resume: got en=%b addr=%h expected en=1 addr=0010", bus.imem_en, bus.imem_addr); end
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0040;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL redir_no_issue: got imem_en=%b expected 0", bus.imem_en); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0000) begin errors++; $display("FAIL redir_pre_head: got v=%b pc=%h expected v=1 pc=0000", bus.out_valid, bus.out_pc); end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.imem_en !== 1'b1 || bus.imem_addr !== 16'h0040) begin errors++; $display("FAIL redir_next: got v=%b en=%b addr=%h expected v=0 en=1 addr=0040", bus.out_valid, bus.imem_en, bus.imem_addr); end
        @(negedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 16'h0044) begin errors++; $display("FAIL redir_gap: got v=%b addr=%h expected v=0 addr=0044", bus.out_valid, bus.imem_addr); end
        @(negedge clk); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0040 || bus.out_pred_npc !== 16'h0044) begin errors++; $display("FAIL redir_first_out: got v=%b pc=%h npc=%h expected v=1 pc=0040 npc=0044", bus.out_valid, bus.out_pc, bus.out_pred_npc); end
        @(negedge clk); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0044) begin errors++; $display("FAIL redir_second_out: got v=%b pc=%h expected v=1 pc=0044", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_reset_redirect();
        do_reset(1'b1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0040;
        #1;
        checks++; if (bus.imem_en !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rr_during: got en=%b v=%b expected en=0 v=0", bus.imem_en, bus.out_valid); end
        @(negedge clk);
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        #1;
        checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 16'h0000 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rr_after: got en=%b addr=%h v=%b expected en=1 addr=0000 v=0", bus.imem_en, bus.imem_addr, bus.out_valid); end
        @(negedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rr_empty: got out_valid=%b expected 0", bus.out_valid); end
        @(negedge clk); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0000) begin errors++; $display("FAIL rr_first_out: got v=%b pc=%h expected v=1 pc=0000", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'hFFF8;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        checks++; if (bus.imem_addr !== 16'hFFF8) begin errors++; $display("FAIL wrap_a: got %h expected fff8", bus.imem_addr); end
        @(negedge clk); #1;
        checks++; if (bus.imem_addr !== 16'hFFFC) begin errors++; $display("FAIL wrap_b: got %h expected fffc", bus.imem_addr); end
        @(negedge clk); #1;
        checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_c: got %h expected 0000", bus.imem_addr); end
        checks++; if (bus.out_pc !== 16'hFFF8 || bus.out_pred_npc !== 16'hFFFC) begin errors++; $display("FAIL wrap_out_a: got pc=%h npc=%h expected fff8/fffc", bus.out_pc, bus.out_pred_npc); end
        @(negedge clk); #1;
        checks++; if (bus.out_pc !== 16'hFFFC || bus.out_pred_npc !== 16'h0000) begin errors++; $display("FAIL wrap_out_b: got pc=%h npc=%h expected fffc/0000", bus.out_pc, bus.out_pred_npc); end
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.out_ready = 1'b0;
        test_reset();
        test_sequential(0);
`ifdef FETCH_BTB_PRED_EN
        test_btb_taken();
`else
        test_sequential(1);
`endif
        test_backpressure();
        test_redirect();
        test_reset_redirect();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC loaded on reset.
REQ-002 Parameter FQ_DEPTH, default 4, fetch queue entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_en  output  1  instruction memory read enable.
REQ-006 imem_addr  output  16  byte address of fetched instruction.
REQ-007 imem_rdata  input  32  instruction; valid exactly one cycle after imem_en=1.
REQ-008 btb_pc  output  16  PC presented to branch target buffer (combinational lookup).
REQ-009 btb_npc  input  16  predicted next PC from BTB for btb_pc.
REQ-010 redirect_valid  input  1  mispredict/redirect from execute.
REQ-011 redirect_pc  input  16  corrected PC.
REQ-012 out_valid  output  1  decode-side entry available.
REQ-013 out_ready  input  1  decode accepts entry when out_valid&&out_ready.
REQ-014 out_pc / out_inst / out_pred_npc  output  16/32/16  head entry fields.

Function
REQ-015 Issue: when issue_ok, imem_en=1, imem_addr=btb_pc=pc, and pc<=predicted NPC at posedge.
REQ-016 issue_ok = !redirect_valid && (queue occupancy + in-flight count) < FQ_DEPTH; occupancy taken before this cycle's pop.
REQ-017 When !issue_ok, imem_en=0 and pc holds.
REQ-018 In-flight slot (1 deep) records pc and predicted NPC of issued fetch; next cycle imem_rdata is pushed as {pc, inst, pred_npc} unless killed.
REQ-019 Latency: fetch issued in cycle N appears as out_valid at cycle N+2 earliest; sustained throughput one instruction/cycle with out_ready=1.
REQ-020 Queue is in-order FIFO; simultaneous push and pop allowed at any occupancy including full and empty; no entry dropped or duplicated.
REQ-021 Pointer wrap-around modulo FQ_DEPTH; occupancy counter width clog2(FQ_DEPTH)+1.
REQ-022 Redirect (priority over issue, push and pop): at posedge pc<=redirect_pc, queue emptied, in-flight data killed (not pushed); out_valid=0 next cycle; redirect_pc issued the cycle after redirect.
REQ-023 Redirect while out_valid&&out_ready in same cycle: handshake is discarded (decode must ignore it; execute flushes younger).
REQ-024 PC arithmetic 16-bit, fallthrough pc+4 wraps 16'hFFFC -> 16'h0000; bits [1:0] of predicted NPC forced to 0.

Reset
REQ-025 rst: pc<=RESET_PC, queue empty, in-flight cleared; out_valid=0, imem_en=0 during the rst cycle.
REQ-026 rst asserted mid-operation behaves identically and overrides redirect_valid; first fetch (RESET_PC) issued the cycle after rst deasserts.

Configuration
REQ-027 Macro FETCH_BTB_PRED_EN defined: predicted NPC = btb_npc.
REQ-028 Macro undefined: predicted NPC = pc+4; btb_npc ignored; btb_pc still driven; ports unchanged.

Structure
REQ-029 Shared package holds PC_W=16, INST_W=32, RESET_PC default, fetch entry struct {pc, inst, pred_npc}.
REQ-030 FIFO is a separate sub-module fetch_queue (parameterized depth, flush input, push/pop, occupancy output).

Verification
REQ-031 Reset, BTB returns pc+4, out_ready=1 -> imem_addr 0x0000,0x0004,0x0008...; out_pc 0x0000 at cycle 2 after rst release, then one per cycle.
REQ-032 BTB returns 0x0100 for pc 0x0008 -> out_pc 0x0000,0x0004,0x0008,0x0100; out_pred_npc of 0x0008 entry = 0x0100.
REQ-033 out_ready=0 for 10 cycles -> exactly 4 entries buffered, imem_en=0 once full; release -> 0x0000..0x000C then 0x0010 in order, no gaps.
REQ-034 redirect_valid, redirect_pc=0x0040 with queue non-empty and fetch in flight -> next cycle out_valid=0, imem_addr=0x0040; next out_pc=0x0040, no stale entry.
REQ-035 rst and redirect_valid (0x0040) same cycle -> next fetch address RESET_PC, queue empty.
REQ-036 FETCH_BTB_PRED_EN undefined, btb_npc forced 0x0100 -> sequential out_pc 0x0000,0x0004,0x0008,0x000C.
